display_share_arbiter: RTL

Round-robin scheduler that shares the board's eight-digit, two-number seven-segment display among four requesters (e.g. PC, ALU result, register probe, memory probe). It sits directly upstream of the two-number display driver and produces that driver's `NumberA`/`NumberB` inputs. Each owner keeps the display for a guaranteed minimum dwell time, and a `Hold` switch freezes the current owner for inspection.

---
 rtl/display_share_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/display_share_arbiter.sv
// Round-robin owner of the shared two-number display: picks one of four requesters,
// keeps it for a minimum dwell under contention, and feeds its numbers to the driver.
module display_share_arbiter #(
    parameter int NUM_WIDTH    = 16,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [3:0]             Req,
    input  logic [4*NUM_WIDTH-1:0] ReqNumA,
    input  logic [4*NUM_WIDTH-1:0] ReqNumB,
    input  logic                   Hold,
    output logic [3:0]             Grant,
    output logic [3:0]             Ack,
    output logic [NUM_WIDTH-1:0]   NumberA,
    output logic [NUM_WIDTH-1:0]   NumberB,
    output logic [1:0]             Owner,
    output logic                   OwnerValid
);

    localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             ack_q, ack_d;
    logic [NUM_WIDTH-1:0]   numa_q, numa_d;
    logic [NUM_WIDTH-1:0]   numb_q, numb_d;

    logic [2:0]             pick_any;
    logic [2:0]             pick_other;
    logic                   grant_evt;
    logic [1:0]             new_owner;

    // Returns {found, index}; the owner itself is only a candidate when incl_self is set.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base,
                                           input logic incl_self);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, base};
        for (int k = 4; k >= 1; k--) begin
            idx = base + k[1:0];
            if (req[idx] && (k != 4 || incl_self)) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_WIDTH-1:0] slice(input logic [4*NUM_WIDTH-1:0] v,
                                                  input logic [1:0] i);
        logic [NUM_WIDTH-1:0] s;
        case (i)
            2'd0:    s = v[0*NUM_WIDTH +: NUM_WIDTH];
            2'd1:    s = v[1*NUM_WIDTH +: NUM_WIDTH];
            2'd2:    s = v[2*NUM_WIDTH +: NUM_WIDTH];
            default: s = v[3*NUM_WIDTH +: NUM_WIDTH];
        endcase
        return s;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            owner_q <= 2'd3;
            cnt_q   <= '0;
            ack_q   <= '0;
            numa_q  <= '0;
            numb_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            numa_q  <= numa_d;
            numb_q  <= numb_d;
        end
    end

    always_comb begin
        pick_any   = rr_pick(Req, owner_q, 1'b1);
        pick_other = rr_pick(Req, owner_q, 1'b0);
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        numa_d     = numa_q;
        numb_d     = numb_q;
        grant_evt  = 1'b0;
        new_owner  = owner_q;

        case (state_q)
            IDLE: begin
                if (pick_any[2]) begin
                    grant_evt = 1'b1;
                    new_owner = pick_any[1:0];
                end
            end
            default: begin
                numa_d = slice(ReqNumA, owner_q);
                numb_d = slice(ReqNumB, owner_q);
                // Hold freezes both ownership and the dwell count, even on owner drop.
                if (!Hold) begin
                    if (!Req[owner_q]) begin
                        if (pick_other[2]) begin
                            grant_evt = 1'b1;
                            new_owner = pick_other[1:0];
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        if (pick_other[2]) begin
                            grant_evt = 1'b1;
                            new_owner = pick_other[1:0];
                        end else begin
                            cnt_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase

        if (grant_evt) begin
            state_d = SHOW;
            owner_d = new_owner;
            cnt_d   = '0;
            ack_d   = 4'b0001 << new_owner;
            numa_d  = slice(ReqNumA, new_owner);
            numb_d  = slice(ReqNumB, new_owner);
        end
    end

    always_comb begin
        Grant      = (state_q == SHOW) ? (4'b0001 << owner_q) : 4'b0000;
        OwnerValid = (state_q == SHOW);
        Ack        = ack_q;
        NumberA    = numa_q;
        NumberB    = numb_q;
        Owner      = owner_q;
    end

endmodule
